dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 p0_req  in  1  port 0 (load/store unit) access request; held high until p0_ack.
REQ-004 p0_we  in  1  port 0 write (1) / read (0); stable while p0_req high.
REQ-005 p0_addr  in  32  port 0 byte address; stable while p0_req high.
REQ-006 p0_wdata  in  32  port 0 write data; stable while p0_req high.
REQ-007 p0_ack  out  1  single-cycle completion pulse to port 0.
REQ-008 p0_rdata  out  32  port 0 read data; valid only in the p0_ack cycle.
REQ-009 p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same widths and meaning as port 0, for port 1 (debug/loader).
REQ-010 mem_read  out  1  data memory read strobe.
REQ-011 mem_write  out  1  data memory write strobe.
REQ-012 mem_addr  out  32  data memory address.
REQ-013 mem_wdata  out  32  data memory write data.
REQ-014 mem_rdata  in  32  data memory read data; valid the cycle after mem_read.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, DONE; reset state IDLE.
REQ-016 IDLE: with no req, remain IDLE with all memory strobes low.
REQ-017 IDLE with at least one req: register the winner id, we, addr, wdata; go to ACCESS.
REQ-018 ACCESS: drive mem_addr = {latched addr[31:2], 2'b00}; mem_wdata = latched wdata; assert exactly one of mem_write (we=1) or mem_read (we=0) for one cycle; go to DONE.
REQ-019 DONE: pulse the winner's ack for one cycle; for reads, drive its rdata from mem_rdata; go to IDLE.
REQ-020 Latency: req sampled at edge N, strobe during cycle N+1, ack during cycle N+2; next grant no earlier than edge N+3.
REQ-021 mem_read and mem_write SHALL never be high together, and SHALL be low outside ACCESS.
REQ-022 A req still high in IDLE after its ack SHALL be treated as a new request.
REQ-023 The losing port's req SHALL stay pending, with no ack, until it is granted.
REQ-024 rdata outputs SHALL hold their last value outside ack cycles; the non-winning port's ack SHALL remain 0.
REQ-025 A change of req inputs during ACCESS or DONE SHALL not affect the transaction in flight.

Reset
REQ-026 On reset: state IDLE; p0_ack, p1_ack, mem_read, mem_write = 0; mem_addr, mem_wdata, p0_rdata, p1_rdata = 0; priority pointer = port 0.
REQ-027 Reset asserted in ACCESS or DONE SHALL abort the transaction: no ack, and strobes low from the next cycle.

Configuration
REQ-028 Macro DMEM_ARB_RR_EN defined: round-robin arbitration; on simultaneous requests grant the port not granted last; the pointer updates on each grant.
REQ-029 Macro undefined: fixed priority, port 0 always wins simultaneous requests, and no pointer register exists.

Structure
REQ-030 Package dmem_arb_pkg SHALL hold the state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the port id constants PORT0=1'b0 and PORT1=1'b1.
REQ-031 One sub-module, dmem_arb_grant, SHALL implement the combinational grant plus the priority pointer; the FSM and datapath latches SHALL stay in dmem_arbiter.

Verification
REQ-032 P0 write 0xCAFEBABE to 0x0, then P0 read 0x0 -> single mem_write in cycle N+1, p0_ack at N+2, then p0_rdata=0xCAFEBABE with p0_ack.
REQ-033 P0 and P1 request on the same edge; P0 writes 0x11111111 to 0x4, P1 reads 0x8 -> P0 served first, P1 acked three cycles later, with no overlapping strobes.
REQ-034 With DMEM_ARB_RR_EN, both ports request continuously for 6 grants -> grants alternate P0, P1, P0, ...; without the macro -> all 6 grants go to P0 and P1 starves.
REQ-035 P1 read of addr 0x0000000B -> mem_addr=0x00000008.
REQ-036 Reset pulsed during ACCESS of a P1 write -> no p1_ack, FSM in IDLE, all outputs 0 on the next cycle.
REQ-037 Assertion check over all runs: mem_read and mem_write are never high together, and at most one ack is high per cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared encodings and the latched transaction record for the data-memory arbiter.
// Arbitration policy is selected in dmem_arb_grant by DMEM_ARB_RR_EN.
package dmem_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef struct packed {
        logic        id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational grant for two ports; DMEM_ARB_RR_EN adds a round-robin
// pointer, otherwise port 0 wins every tie and no state exists here.
module dmem_arb_grant
    import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
    input  logic clk_i,
    input  logic rst_i,
`endif
    input  logic req0_i,
    input  logic req1_i,
    input  logic take_i,
    output logic valid_o,
    output logic id_o
);

    assign valid_o = req0_i | req1_i;

`ifdef DMEM_ARB_RR_EN
    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (req0_i && req1_i) begin
            id_o = ptr_q;
        end else begin
            id_o = req0_i ? PORT0 : PORT1;
        end
        // Tie priority goes to the port that did not win this grant.
        if (take_i && valid_o) begin
            ptr_d = ~id_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_take;
    assign unused_take = take_i;
    assign id_o = req0_i ? PORT0 : PORT1;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE -> ACCESS (one strobe) -> DONE (ack).
// Define DMEM_ARB_RR_EN for round-robin ties; default is port 0 priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    logic [1:0]  state_q, state_d;
    txn_t        txn_q, txn_d;
    logic [31:0] p0_rdata_q, p1_rdata_q;
    logic        gnt_valid, gnt_id, idle;
    logic        in_access, in_done;

    assign idle      = (state_q == IDLE);
    assign in_access = (state_q == ACCESS);
    assign in_done   = (state_q == DONE);

    dmem_arb_grant u_grant (
`ifdef DMEM_ARB_RR_EN
        .clk_i   (clk),
        .rst_i   (reset),
`endif
        .req0_i  (p0_req),
        .req1_i  (p1_req),
        .take_i  (idle),
        .valid_o (gnt_valid),
        .id_o    (gnt_id)
    );

    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    txn_d.id = gnt_id;
                    if (gnt_id == PORT1) begin
                        txn_d.we    = p1_we;
                        txn_d.addr  = word_addr(p1_addr);
                        txn_d.wdata = p1_wdata;
                    end else begin
                        txn_d.we    = p0_we;
                        txn_d.addr  = word_addr(p0_addr);
                        txn_d.wdata = p0_wdata;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_read  = in_access & ~txn_q.we;
    assign mem_write = in_access & txn_q.we;
    assign mem_addr  = txn_q.addr;
    assign mem_wdata = txn_q.wdata;

    // A reset landing in DONE suppresses the ack of the aborted transfer.
    assign p0_ack = in_done & (txn_q.id == PORT0) & ~reset;
    assign p1_ack = in_done & (txn_q.id == PORT1) & ~reset;

    assign p0_rdata = (p0_ack && !txn_q.we) ? mem_rdata : p0_rdata_q;
    assign p1_rdata = (p1_ack && !txn_q.we) ? mem_rdata : p1_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            txn_q      <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            txn_q      <= txn_d;
            p0_rdata_q <= p0_rdata;
            p1_rdata_q <= p1_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked by a transaction-level model of the arbiter and memory.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        p0_req, p0_we, p0_ack;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_ack;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int compared   = 0;
    int mismatched = 0;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_ack    (p0_ack),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_ack    (p1_ack),
        .p1_rdata  (p1_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory device: 256 words, read data returned the cycle after mem_read.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr[9:2]];
    end

    // Reference model state: a transfer occupies two cycles after its grant.
    logic [31:0] ref_mem [0:255];
    int          m_cnt = 0;
    logic        m_id = 1'b0, m_we = 1'b0, m_last = 1'b1;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [31:0] m_rd0 = '0, m_rd1 = '0;
    logic        mon_on = 1'b0;
    int          nwr = 0, nrd = 0;
    logic [31:0] last_strobe_addr = '0;

    logic        s_reset, s_req0, s_req1, s_we0, s_we1;
    logic [31:0] s_a0, s_a1, s_d0, s_d1;
    always @(posedge clk) begin
        s_reset <= reset;
        s_req0  <= p0_req;
        s_req1  <= p1_req;
        s_we0   <= p0_we;
        s_we1   <= p1_we;
        s_a0    <= p0_addr;
        s_a1    <= p1_addr;
        s_d0    <= p0_wdata;
        s_d1    <= p1_wdata;
    end

    always @(negedge clk) begin
        logic w, er, ew, e0, e1;
        if (s_reset === 1'b1) begin
            m_cnt = 0; m_last = 1'b1; m_rd0 = '0; m_rd1 = '0;
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else if (s_req0 === 1'b1 || s_req1 === 1'b1) begin
            if (s_req0 && s_req1) begin
`ifdef DMEM_ARB_RR_EN
                w = ~m_last;
`else
                w = 1'b0;
`endif
            end else begin
                w = s_req1;
            end
            m_last  = w;
            m_id    = w;
            m_we    = w ? s_we1 : s_we0;
            m_addr  = w ? s_a1 : s_a0;
            m_wdata = w ? s_d1 : s_d0;
            m_cnt   = 2;
        end
        er = (m_cnt == 2) && !m_we;
        ew = (m_cnt == 2) && m_we;
        e0 = (m_cnt == 1) && (m_id == 1'b0) && !reset;
        e1 = (m_cnt == 1) && (m_id == 1'b1) && !reset;
        if (e0 && !m_we) m_rd0 = ref_mem[m_addr[9:2]];
        if (e1 && !m_we) m_rd1 = ref_mem[m_addr[9:2]];
        if (ew) ref_mem[m_addr[9:2]] = m_wdata;
        if (mem_write === 1'b1) nwr++;
        if (mem_read === 1'b1) nrd++;
        if (mem_read === 1'b1 || mem_write === 1'b1)
            last_strobe_addr = mem_addr;
        if (mon_on) begin
            compared++;
            if ({mem_read, mem_write} !== {er, ew}) begin
                mismatched++;
                $display("FAIL mon_strobe t=%0t: rd/wr %b%b want %b%b",
                         $time, mem_read, mem_write, er, ew);
            end
            if (m_cnt == 2) begin
                compared++;
                if (mem_addr !== (m_addr & 32'hFFFF_FFFC) ||
                    (m_we && mem_wdata !== m_wdata)) begin
                    mismatched++;
                    $display("FAIL mon_addr t=%0t: addr %h data %h want %h %h",
                             $time, mem_addr, mem_wdata,
                             m_addr & 32'hFFFF_FFFC, m_wdata);
                end
            end
            compared++;
            if ({p0_ack, p1_ack} !== {e0, e1}) begin
                mismatched++;
                $display("FAIL mon_ack t=%0t: acks %b%b want %b%b",
                         $time, p0_ack, p1_ack, e0, e1);
            end
            compared++;
            if (p0_rdata !== m_rd0 || p1_rdata !== m_rd1) begin
                mismatched++;
                $display("FAIL mon_rdata t=%0t: %h %h want %h %h",
                         $time, p0_rdata, p1_rdata, m_rd0, m_rd1);
            end
            compared++;
            if ((mem_read && mem_write) || (p0_ack && p1_ack)) begin
                mismatched++;
                $display("FAIL mon_exclusive t=%0t: rd %b wr %b a0 %b a1 %b",
                         $time, mem_read, mem_write, p0_ack, p1_ack);
            end
        end
    end

    int          la, lb;
    logic [31:0] ra, rb;

    task automatic xfer(input int port, input logic we,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd);
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
        end
        lat = -1;
        rd  = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((port == 0 && p0_ack === 1'b1) ||
                (port == 1 && p1_ack === 1'b1)) begin
                lat = i;
                rd  = (port == 0) ? p0_rdata : p1_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        if (port == 0) p0_req = 1'b0;
        else p1_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; p0_req = 1'b0; p1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 mon_on = 1'b1;
        @(negedge clk);
        compared++;
        if ({p0_ack, p1_ack, mem_read, mem_write} !== 4'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
            p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: ack %b%b strb %b%b addr %h wd %h rd %h %h want all 0",
                     p0_ack, p1_ack, mem_read, mem_write,
                     mem_addr, mem_wdata, p0_rdata, p1_rdata);
        end
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if ({mem_read, mem_write, p0_ack, p1_ack} !== 4'b0) begin
                mismatched++;
                $display("FAIL idle_quiet: strb %b%b ack %b%b want 0000",
                         mem_read, mem_write, p0_ack, p1_ack);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int w0;
        do_reset();
        w0 = nwr;
        xfer(0, 1'b1, 32'h0, 32'hCAFEBABE, la, ra);
        compared++;
        if (la !== 3 || nwr - w0 !== 1) begin
            mismatched++;
            $display("FAIL wr_latency: ack cycle %0d writes %0d want 3 and 1",
                     la, nwr - w0);
        end
        xfer(0, 1'b0, 32'h0, 32'h0, la, ra);
        compared++;
        if (la !== 3 || ra !== 32'hCAFEBABE) begin
            mismatched++;
            $display("FAIL rd_back: ack cycle %0d data %h want 3 cafebabe",
                     la, ra);
        end
        @(negedge clk);
        compared++;
        if (p0_rdata !== 32'hCAFEBABE || p0_ack !== 1'b0) begin
            mismatched++;
            $display("FAIL rd_hold: data %h ack %b want cafebabe 0",
                     p0_rdata, p0_ack);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous();
        do_reset();
        xfer(1, 1'b1, 32'h8, 32'h5A5A1234, la, ra);
        do_reset();
        fork
            xfer(0, 1'b1, 32'h4, 32'h11111111, la, ra);
            xfer(1, 1'b0, 32'h8, 32'h0, lb, rb);
        join
        compared++;
        if (la !== 3 || lb !== 6) begin
            mismatched++;
            $display("FAIL simul_order: p0 ack %0d p1 ack %0d want 3 6", la, lb);
        end
        compared++;
        if (rb !== 32'h5A5A1234) begin
            mismatched++;
            $display("FAIL simul_rdata: p1 data %h want 5a5a1234", rb);
        end
    endtask

    task automatic test_arbitration();
        logic ids [6];
        int   n = 0;
        logic exp;
        do_reset();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10; p0_wdata = '0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h14; p1_wdata = '0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (p0_ack === 1'b1) begin ids[n] = 1'b0; n++; end
            else if (p1_ack === 1'b1) begin ids[n] = 1'b1; n++; end
        end
        @(posedge clk); #1;
        p0_req = 1'b0; p1_req = 1'b0;
        compared++;
        if (n !== 6) begin
            mismatched++;
            $display("FAIL arb_count: grants %0d want 6", n);
        end
        for (int i = 0; i < n; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp = i[0];
`else
            exp = 1'b0;
`endif
            compared++;
            if (ids[i] !== exp) begin
                mismatched++;
                $display("FAIL arb_grant%0d: port %b want %b", i, ids[i], exp);
            end
        end
    endtask

    task automatic test_align();
        do_reset();
        xfer(1, 1'b0, 32'h0000000B, 32'h0, la, ra);
        compared++;
        if (last_strobe_addr !== 32'h8 || ra !== 32'h5A5A1234 || la !== 3) begin
            mismatched++;
            $display("FAIL align: mem_addr %h data %h ack %0d want 8 5a5a1234 3",
                     last_strobe_addr, ra, la);
        end
    endtask

    task automatic test_reset_abort();
        logic acked = 1'b0;
        do_reset();
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (mem_write !== 1'b1 || mem_addr !== 32'h20) begin
            mismatched++;
            $display("FAIL abort_access: wr %b addr %h want 1 20",
                     mem_write, mem_addr);
        end
        #1 reset = 1'b1; p1_req = 1'b0;
        @(negedge clk);
        compared++;
        if ({p0_ack, p1_ack, mem_read, mem_write} !== 4'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
            p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            mismatched++;
            $display("FAIL abort_outputs: ack %b%b strb %b%b addr %h wd %h rd %h %h want all 0",
                     p0_ack, p1_ack, mem_read, mem_write,
                     mem_addr, mem_wdata, p0_rdata, p1_rdata);
        end
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (p1_ack === 1'b1) acked = 1'b1;
        end
        compared++;
        if (acked !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_noack: p1_ack seen %b want 0", acked);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic seen0 = 1'b0, seen1 = 1'b0;
        int   acks = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 79) == 0);
            if (seen0) p0_req = ($urandom_range(0, 3) == 0);
            else if (!p0_req) p0_req = $urandom_range(0, 1) == 1;
            if (p0_req && (seen0 || !s_req0)) begin
                p0_we = $urandom_range(0, 1) == 1;
                p0_addr = 32'($urandom_range(0, 1023));
                p0_wdata = $urandom;
            end
            if (seen1) p1_req = ($urandom_range(0, 3) == 0);
            else if (!p1_req) p1_req = $urandom_range(0, 1) == 1;
            if (p1_req && (seen1 || !s_req1)) begin
                p1_we = $urandom_range(0, 1) == 1;
                p1_addr = 32'($urandom_range(0, 1023));
                p1_wdata = $urandom;
            end
            @(negedge clk);
            seen0 = (p0_ack === 1'b1);
            seen1 = (p1_ack === 1'b1);
            if (seen0 || seen1) acks++;
        end
        @(posedge clk); #1;
        reset = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
        compared++;
        if (acks < 50) begin
            mismatched++;
            $display("FAIL random_progress: acks %0d want at least 50", acks);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        mem_rdata = '0;
        reset = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        test_reset();
        test_write_read();
        test_simultaneous();
        test_arbitration();
        test_align();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
